bcd_seq_conv: RTL
=================

BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 SHALL have parameter W, default 9, meaning binary input width, legal range 1..9.
REQ-002 SHALL have parameter LZB, default 1, meaning leading-zero blanking enable (1 = blank, 0 = print zeros).
REQ-003 SHALL have port clk_i  input  1  meaning single clock, rising-edge active.
REQ-004 SHALL have port rst_ni  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  meaning request, bin_i valid.
REQ-006 SHALL have port bin_i  input  W  meaning unsigned binary value, e.g. 9-bit adder sum.
REQ-007 SHALL have port ready_o  output  1  meaning request accepted on an edge where valid_i && ready_o.
REQ-008 SHALL have port valid_o  output  1  meaning one-cycle pulse, dec_o updated this cycle.
REQ-009 SHALL have port dec_o  output  3x8 unpacked array [2:0]  meaning ASCII digits for the LCD data_i: [2] = hundreds, [1] = tens, [0] = units.
REQ-010 SHALL have port busy_o  output  1  meaning a conversion is in progress.

Function
REQ-011 SHALL implement states IDLE, SHIFT, FMT, held in a registered state variable.
REQ-012 SHALL hold ready_o = 1 when state is IDLE or the pending slot is empty; otherwise ready_o = 0.
REQ-013 SHALL, on an accept edge in IDLE, load bin_i into the shift register, clear the 12-bit BCD register and the bit counter, and go to SHIFT.
REQ-014 SHALL, on an accept edge in SHIFT or FMT, store bin_i in a one-deep pending slot and mark the slot full; it never overwrites a full slot.
REQ-015 SHALL, on each SHIFT edge, first add 3 to every BCD nibble >= 5, then shift {BCD, shift reg} left by 1 and increment the counter.
REQ-016 SHALL leave SHIFT for FMT on the edge that completes the W-th shift.
REQ-017 SHALL, on the FMT edge, register dec_o and assert valid_o for exactly one cycle.
REQ-018 SHALL encode each digit as 0x30 + nibble.
REQ-019 SHALL, when LZB = 1, output 0x20 for hundreds if it is 0, and 0x20 for tens if both hundreds and tens are 0; units is never blanked and internal zeros are never blanked.
REQ-020 SHALL, on the FMT edge with the pending slot full, load the pending value, clear the slot, and go directly to SHIFT; otherwise go to IDLE.
REQ-021 SHALL give a latency of W+1 edges from the accept edge to valid_o high (10 cycles for W = 9); back-to-back results are W+1 cycles apart.
REQ-022 SHALL hold dec_o stable between valid_o pulses.
REQ-023 SHALL ignore valid_i when ready_o = 0, with no state change.
REQ-024 SHALL assert busy_o exactly when state is not IDLE.
REQ-025 SHALL correctly convert every value in 0..2^W-1 (max 511 -> "511").

Reset
REQ-026 SHALL, while rst_ni = 0, asynchronously force state IDLE, the pending slot empty, the counter and BCD register to 0, valid_o = 0, busy_o = 0 and ready_o = 1.
REQ-027 SHALL reset dec_o to {0x20, 0x20, 0x30} when LZB = 1, and to {0x30, 0x30, 0x30} when LZB = 0.
REQ-028 SHALL, on reset asserted mid-conversion, discard both the in-flight value and the pending value; no valid_o pulse follows deassertion.

Verification
REQ-029 SHALL cover: bin_i = 0, LZB = 1, accepted at edge 0 -> valid_o high after edge 10, dec_o = {0x20, 0x20, 0x30}.
REQ-030 SHALL cover: bin_i = 510 (255+255) -> dec_o = {0x35, 0x31, 0x30}; bin_i = 511 -> {0x35, 0x31, 0x31}.
REQ-031 SHALL cover: bin_i = 7 -> {0x20, 0x20, 0x37}; bin_i = 105 -> {0x31, 0x30, 0x35}; with LZB = 0, bin_i = 7 -> {0x30, 0x30, 0x37}.
REQ-032 SHALL cover: 123 accepted at edge 0, 456 offered at edge 3, 789 offered at edge 5 -> 456 accepted, then ready_o = 0 and 789 not accepted; valid_o pulses with "123" after edge 10 and with "456" after edge 20, busy_o high throughout, then IDLE.
REQ-033 SHALL cover: rst_ni pulsed low at edge 4 of a conversion of 300 -> dec_o = {0x20, 0x20, 0x30} and ready_o = 1 immediately, no valid_o pulse; a following request for 42 yields {0x20, 0x34, 0x32}.
REQ-034 SHALL cover: random bin_i values in 0..511 with random valid_i -> every accepted value produces exactly one valid_o pulse, in order, matching a reference decimal model.

Source files
------------

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-ASCII-decimal converter (double dabble) feeding a
// three-digit LCD field. One conversion in flight plus a one-deep pending slot.
//
// state | meaning
// IDLE  | no conversion running, ready for a request
// SHIFT | add-3 / shift-left iterations, one input bit per cycle
// FMT   | BCD complete, format ASCII digits and pulse valid_o
module bcd_seq_conv #(
  parameter int W   = 9,
  parameter bit LZB = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [W-1:0] bin_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [7:0]   dec_o [2:0],
  output logic         busy_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [7:0] HUND_RST = LZB ? 8'h20 : 8'h30;
  localparam logic [7:0] TENS_RST = LZB ? 8'h20 : 8'h30;

  typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   pend_q;
  logic           pend_full_q;
  logic [11:0]    bcd_q;
  logic [11:0]    bcd_adj;
  logic [CW-1:0]  cnt_q;
  logic           accept;
  logic           start;
  logic [W-1:0]   start_val;
  logic           pend_store;
  logic           pend_clear;
  logic           fmt;
  logic [3:0]     hund, tens, units;
  logic [7:0]     ch_hund, ch_tens, ch_units;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, handshake and datapath control decode.
  always_comb begin
    state_d    = state_q;
    ready_o    = (state_q == IDLE) || !pend_full_q;
    accept     = valid_i && ready_o;
    busy_o     = (state_q != IDLE);
    start      = 1'b0;
    start_val  = bin_i;
    pend_store = 1'b0;
    pend_clear = 1'b0;
    fmt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        pend_store = accept;
        if (cnt_q == LAST_CNT) state_d = FMT;
      end
      FMT: begin
        fmt = 1'b1;
        // A request arriving in FMT with an empty slot starts immediately
        // rather than parking in the slot, so nothing is left stranded in IDLE.
        if (pend_full_q) begin
          start      = 1'b1;
          start_val  = pend_q;
          pend_clear = 1'b1;
          state_d    = SHIFT;
        end else if (accept) begin
          start   = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Shift register, BCD accumulator and bit counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sr_q  <= start_val;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      bcd_q <= {bcd_adj[10:0], sr_q[W-1]};
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // One-deep pending slot; never written while full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (pend_clear) begin
      pend_full_q <= 1'b0;
    end else if (pend_store) begin
      pend_q      <= bin_i;
      pend_full_q <= 1'b1;
    end
  end

  // ASCII formatting with optional leading-zero blanking.
  always_comb begin
    hund     = bcd_q[11:8];
    tens     = bcd_q[7:4];
    units    = bcd_q[3:0];
    ch_hund  = (LZB && hund == 4'd0) ? 8'h20 : (8'h30 + {4'h0, hund});
    ch_tens  = (LZB && hund == 4'd0 && tens == 4'd0) ? 8'h20 : (8'h30 + {4'h0, tens});
    ch_units = 8'h30 + {4'h0, units};
  end

  // Output register: digits update and valid_o pulses only on the FMT cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      dec_o[2] <= HUND_RST;
      dec_o[1] <= TENS_RST;
      dec_o[0] <= 8'h30;
    end else begin
      valid_o <= fmt;
      if (fmt) begin
        dec_o[2] <= ch_hund;
        dec_o[1] <= ch_tens;
        dec_o[0] <= ch_units;
      end
    end
  end

endmodule
